rename_reg_file: RTL
====================

Name: rename_reg_file

Overview:
Parametrised architectural register file with per-register ROB rename tags, the successor of the single-rename-port register file. Sits between the decoder/dispatch stage (read operands, claim destinations) and the ROB commit stage (retire values). Adds the following over the previous generation:
- configurable read-port count;
- two rename ports per cycle (dual dispatch) with in-order priority;
- a misprediction flush that clears all rename state;
- proper synchronous reset of every entry.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hard-wired to zero.
DATA_W, 32, register data width.
TAG_W, 4, ROB tag width.
NUM_READ, 4, number of combinational read ports (>=1).
ZERO_TAG, 0, tag value meaning "no producer".
Localparam REG_W = $clog2(NUM_REGS).

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
rd_idx  in  NUM_READ*REG_W  packed read indices; port i occupies bits [i*REG_W +: REG_W]
rd_value  out  NUM_READ*DATA_W  packed read data
rd_tag  out  NUM_READ*TAG_W  packed producer tag per read port
rd_busy  out  NUM_READ  1 = value pending on rd_tag
ren0_valid  in  1  rename request 0 (older instruction)
ren0_reg  in  REG_W  destination register for rename 0
ren0_tag  in  TAG_W  ROB tag for rename 0
ren1_valid  in  1  rename request 1 (younger instruction)
ren1_reg  in  REG_W  destination register for rename 1
ren1_tag  in  TAG_W  ROB tag for rename 1
cm_valid  in  1  ROB commit strobe
cm_reg  in  REG_W  committed destination register
cm_tag  in  TAG_W  committing ROB tag
cm_value  in  DATA_W  committed value
flush  in  1  misprediction flush
busy_cnt  out  REG_W+1  registered count of busy registers

Behaviour:
- Per register r, state is: data[r] (DATA_W), tag[r] (TAG_W), busy[r].

Reset (rst=1 at posedge):
- all data = 0, all tag = ZERO_TAG, all busy = 0, busy_cnt = 0.
- rst overrides every other input in that cycle.

Reads:
- Purely combinational from current state; zero cycles of latency.
- rd_value/rd_tag/rd_busy for port i reflect data/tag/busy[rd_idx_i] as held before the coming edge.
- Index 0 always returns value 0, tag ZERO_TAG, busy 0.
- Renames and commits in the current cycle are not visible until after the edge (unless REGFILE_BYPASS_EN is defined).

Commit (cm_valid=1, cm_reg!=0):
- data[cm_reg] <= cm_value, unconditionally.
- If cm_tag == tag[cm_reg] and busy[cm_reg], then busy <= 0 and tag <= ZERO_TAG; otherwise the tag is kept (a younger producer owns the register).

Rename (renX_valid=1, renX_reg!=0):
- tag[renX_reg] <= renX_tag; busy <= 1.
- If ren0_reg == ren1_reg, ren1 wins (younger instruction).
- Rename to the same register as a commit in the same cycle: rename wins the tag/busy update; the data write from the commit still occurs.

Flush (flush=1):
- All busy <= 0 and all tag <= ZERO_TAG in the same edge.
- Renames in that cycle are discarded.
- A commit in that cycle still writes data.

Register 0:
- Never written; all writes to it are ignored.

busy_cnt:
- Equals popcount(busy) after each edge; updated on the same edge as busy.
- Maximum value is NUM_REGS-1.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: each read port forwards a same-cycle commit when cm_valid && cm_reg == rd_idx_i != 0:
  - rd_value_i = cm_value;
  - if cm_tag matches the stored tag, rd_busy_i = 0 and rd_tag_i = ZERO_TAG.
  - Same-cycle renames are not forwarded.
- Undefined: reads show only registered state, as described above.
- Sequential state and busy_cnt are identical in both builds.

Test Plan:
- Reset, then read all indices -> value 0, tag 0, busy 0, busy_cnt 0.
- ren0 r5 tag 3 at cycle 1; cycle 2 read r5 -> busy 1, tag 3, busy_cnt 1. Commit r5 tag 3 value 0xDEADBEEF -> next cycle busy 0, tag 0, value 0xDEADBEEF, busy_cnt 0.
- ren0 r7 tag 2, ren1 r7 tag 6 same cycle -> tag 6. Commit r7 tag 2 value 0x11 -> value 0x11, busy stays 1, tag 6.
- Commit r9 tag 4 and ren0 r9 tag 8 same cycle (r9 previously tag 4) -> value updated, busy 1, tag 8.
- Rename r1..r4, then flush together with ren0 r10 tag 1 -> all busy 0, r10 not busy, busy_cnt 0. Writes to r0 are never visible.
- With REGFILE_BYPASS_EN: r3 busy tag 5, commit r3 tag 5 value 0x42 while reading r3 -> same cycle value 0x42, busy 0. Without the macro -> old value, busy 1.

Source files
------------

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename tags, dual rename ports and flush.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle commit onto the read ports.
module rename_reg_file #(
  parameter  int          NUM_REGS = 32,
  parameter  int          DATA_W   = 32,
  parameter  int          TAG_W    = 4,
  parameter  int          NUM_READ = 4,
  parameter  int unsigned ZERO_TAG = 0,
  localparam int          REG_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_READ*REG_W-1:0]  rd_idx,
  output logic [NUM_READ*DATA_W-1:0] rd_value,
  output logic [NUM_READ*TAG_W-1:0]  rd_tag,
  output logic [NUM_READ-1:0]        rd_busy,
  input  logic                       ren0_valid,
  input  logic [REG_W-1:0]           ren0_reg,
  input  logic [TAG_W-1:0]           ren0_tag,
  input  logic                       ren1_valid,
  input  logic [REG_W-1:0]           ren1_reg,
  input  logic [TAG_W-1:0]           ren1_tag,
  input  logic                       cm_valid,
  input  logic [REG_W-1:0]           cm_reg,
  input  logic [TAG_W-1:0]           cm_tag,
  input  logic [DATA_W-1:0]          cm_value,
  input  logic                       flush,
  output logic [REG_W:0]             busy_cnt
);

  localparam logic [TAG_W-1:0] ZTAG = TAG_W'(ZERO_TAG);

  logic [DATA_W-1:0]   data_q [NUM_REGS];
  logic [DATA_W-1:0]   data_d [NUM_REGS];
  logic [TAG_W-1:0]    tag_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_W:0]      busy_cnt_q, busy_cnt_d;
  logic [REG_W-1:0]    sel;

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;

    // Commit data always lands; the tag is released only if this producer still owns it.
    if (cm_valid && cm_reg != '0) begin
      data_d[cm_reg] = cm_value;
      if (cm_tag == tag_q[cm_reg] && busy_q[cm_reg]) begin
        busy_d[cm_reg] = 1'b0;
        tag_d[cm_reg]  = ZTAG;
      end
    end

    if (flush) begin
      busy_d = '0;
      for (int r = 0; r < NUM_REGS; r++) tag_d[r] = ZTAG;
    end else begin
      // ren1 is applied last so the younger instruction wins a shared destination.
      if (ren0_valid && ren0_reg != '0) begin
        tag_d[ren0_reg]  = ren0_tag;
        busy_d[ren0_reg] = 1'b1;
      end
      if (ren1_valid && ren1_reg != '0) begin
        tag_d[ren1_reg]  = ren1_tag;
        busy_d[ren1_reg] = 1'b1;
      end
    end

    data_d[0] = '0;
    tag_d[0]  = ZTAG;
    busy_d[0] = 1'b0;

    busy_cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++)
      busy_cnt_d = busy_cnt_d + {{REG_W{1'b0}}, busy_d[r]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= ZTAG;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  always_comb begin
    rd_value = '0;
    rd_tag   = '0;
    rd_busy  = '0;
    sel      = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      sel = rd_idx[i*REG_W +: REG_W];
      rd_value[i*DATA_W +: DATA_W] = data_q[sel];
      rd_tag[i*TAG_W +: TAG_W]     = tag_q[sel];
      rd_busy[i]                   = busy_q[sel];
`ifdef REGFILE_BYPASS_EN
      if (cm_valid && cm_reg == sel && sel != '0) begin
        rd_value[i*DATA_W +: DATA_W] = cm_value;
        if (cm_tag == tag_q[sel]) begin
          rd_tag[i*TAG_W +: TAG_W] = ZTAG;
          rd_busy[i]               = 1'b0;
        end
      end
`endif
      if (sel == '0) begin
        rd_value[i*DATA_W +: DATA_W] = '0;
        rd_tag[i*TAG_W +: TAG_W]     = ZTAG;
        rd_busy[i]                   = 1'b0;
      end
    end
  end

endmodule
